// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the full-speed USB receive path.
package usb_rx_pkg;

  // Line state, encoded as {dp, dm}.
  typedef enum logic [1:0] {
    LS_SE0 = 2'b00,
    LS_K   = 2'b01,
    LS_J   = 2'b10,
    LS_SE1 = 2'b11
  } line_state_e;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StDiscard,
    StWaitJ
  } rx_state_e;

  // Consecutive ones after which a stuffed zero must follow.
  localparam int unsigned STUFF_LIMIT = 6;

  typedef struct packed {
    logic       err;
    logic       last;
    logic [7:0] data;
  } rx_entry_t;

  localparam int unsigned ENTRY_W = $bits(rx_entry_t);

  function automatic logic is_jk(line_state_e ls);
    return (ls == LS_J) || (ls == LS_K);
  endfunction

endpackage

// File: rtl/usb_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy output.
// A write into a full FIFO is accepted only when a read retires an entry in the same cycle.
module usb_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic                       wr_drop,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LvlW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]  level_q;
  logic             full, do_pop, do_push;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LvlW'(DEPTH));
  assign do_pop  = rd_en && !empty;
  assign do_push = wr_en && (!full || do_pop);
  assign wr_drop = wr_en && !do_push;
  // Head reads as zero when empty so the output is clean out of reset.
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
  assign level   = level_q;

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop) begin
        level_q <= level_q + LvlW'(1);
      end else if (do_pop && !do_push) begin
        level_q <= level_q - LvlW'(1);
      end
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/usb_fs_rx_packetizer.sv
// Full-speed USB receive front end: line classification, NRZI decode, SYNC detection,
// bit unstuffing, LSB-first byte assembly and end-of-packet marking into a FWFT FIFO.
module usb_fs_rx_packetizer
  import usb_rx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned SYNC_MIN_ZEROS = 5,
  parameter int unsigned EOP_SE0_BITS   = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            bit_stb,
  input  logic                            usb_dp,
  input  logic                            usb_dm,
  output logic [7:0]                      rx_data,
  output logic                            rx_last,
  output logic                            rx_err,
  output logic                            rx_valid,
  input  logic                            rx_ready,
  output logic                            rx_active,
  output logic                            rx_ovf,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);

  localparam int unsigned Se0W = (EOP_SE0_BITS > 0) ? $clog2(EOP_SE0_BITS + 1) : 1;

  logic            stb_q;
  line_state_e     ls_q, prev_q, prev_d;
  rx_state_e       state_q, state_d;
  logic [2:0]      zero_cnt_q, zero_cnt_d;
  logic [2:0]      ones_cnt_q, ones_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [Se0W-1:0] se0_cnt_q, se0_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      hold_q, hold_d;
  logic            hold_vld_q, hold_vld_d;
  logic [7:0]      new_byte;
  logic            push;
  rx_entry_t       push_entry, head;
  logic            fifo_empty, fifo_drop, ovf_q, force_discard;
  logic            dec_bit, line_jk, sync_ok, eop_hit, stuff_slot;

  assign dec_bit    = (ls_q == prev_q);
  assign line_jk    = is_jk(ls_q);
  assign sync_ok    = 32'(zero_cnt_q) >= SYNC_MIN_ZEROS;
  assign eop_hit    = (32'(se0_cnt_q) + 32'd1) >= EOP_SE0_BITS;
  assign stuff_slot = 32'(ones_cnt_q) >= STUFF_LIMIT;
  assign new_byte   = {dec_bit, shift_q[7:1]};

  // Capture the line on the bit strobe; the decode below acts on it one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      stb_q <= 1'b0;
      ls_q  <= LS_J;
    end else begin
      stb_q <= bit_stb;
      if (bit_stb) ls_q <= line_state_e'({usb_dp, usb_dm});
    end
  end

  // Receive FSM next state, decode counters and FIFO push request.
  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    zero_cnt_d = zero_cnt_q;
    ones_cnt_d = ones_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    se0_cnt_d  = se0_cnt_q;
    shift_d    = shift_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    push       = 1'b0;
    push_entry = '0;

    if (stb_q) begin
      if (line_jk) prev_d = ls_q;

      unique case (state_q)
        StIdle: begin
          if (ls_q == LS_SE0) begin
            prev_d     = LS_J;
            zero_cnt_d = '0;
          end else if (!line_jk) begin
            zero_cnt_d = '0;
          end else if (!dec_bit) begin
            zero_cnt_d = (zero_cnt_q == 3'd7) ? zero_cnt_q : zero_cnt_q + 3'd1;
          end else begin
            zero_cnt_d = '0;
            if (sync_ok) begin
              state_d    = StData;
              bit_cnt_d  = '0;
              ones_cnt_d = 3'd1;  // the SYNC's closing one counts toward stuffing
              se0_cnt_d  = '0;
            end
          end
        end

        StData: begin
          if (ls_q == LS_SE0) begin
            if (eop_hit) begin
              state_d    = StWaitJ;
              se0_cnt_d  = '0;
              hold_vld_d = 1'b0;
              if (hold_vld_q) begin
                push            = 1'b1;
                push_entry.data = hold_q;
                push_entry.last = 1'b1;
                push_entry.err  = (bit_cnt_q != 3'd0);
              end
            end else begin
              se0_cnt_d = se0_cnt_q + Se0W'(1);
            end
          end else if ((ls_q == LS_SE1) || (stuff_slot && dec_bit)) begin
            // SE1 or a missing stuffed zero aborts the packet.
            state_d    = StDiscard;
            se0_cnt_d  = '0;
            hold_vld_d = 1'b0;
            if (hold_vld_q) begin
              push            = 1'b1;
              push_entry.data = hold_q;
              push_entry.last = 1'b1;
              push_entry.err  = 1'b1;
            end
          end else if (stuff_slot) begin
            // Stuffed zero: dropped, only resets the run of ones.
            se0_cnt_d  = '0;
            ones_cnt_d = '0;
          end else begin
            se0_cnt_d  = '0;
            ones_cnt_d = dec_bit ? ones_cnt_q + 3'd1 : 3'd0;
            shift_d    = new_byte;
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              // Previous byte is known not to be last once another one completes.
              if (hold_vld_q) begin
                push            = 1'b1;
                push_entry.data = hold_q;
              end
              hold_d     = new_byte;
              hold_vld_d = 1'b1;
            end
          end
        end

        StDiscard: begin
          if (ls_q == LS_SE0) state_d = StWaitJ;
        end

        StWaitJ: begin
          if (ls_q == LS_J) begin
            state_d    = StIdle;
            zero_cnt_d = '0;
          end
        end
      endcase
    end
  end

  // A byte lost mid-packet poisons the rest of it.
  assign force_discard = fifo_drop && (state_q == StData) && (state_d == StData);

  // FSM and decode state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      prev_q     <= LS_J;
      zero_cnt_q <= '0;
      ones_cnt_q <= '0;
      bit_cnt_q  <= '0;
      se0_cnt_q  <= '0;
      shift_q    <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= force_discard ? StDiscard : state_d;
      prev_q     <= prev_d;
      zero_cnt_q <= zero_cnt_d;
      ones_cnt_q <= ones_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      se0_cnt_q  <= se0_cnt_d;
      shift_q    <= shift_d;
      hold_q     <= hold_d;
      hold_vld_q <= force_discard ? 1'b0 : hold_vld_d;
      ovf_q      <= fifo_drop;
    end
  end

  usb_sync_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (push),
    .wr_data(push_entry),
    .rd_en  (rx_ready),
    .rd_data(head),
    .empty  (fifo_empty),
    .wr_drop(fifo_drop),
    .level  (fifo_level)
  );

  assign rx_data   = head.data;
  assign rx_last   = head.last;
  assign rx_err    = head.err;
  assign rx_valid  = !fifo_empty;
  assign rx_active = (state_q == StData);
  assign rx_ovf    = ovf_q;

endmodule

// File: tb/tb_usb_fs_rx_packetizer.sv
// Bench for usb_fs_rx_packetizer: a line-level encoder drives SYNC/NRZI/stuffed packets and a
// byte-level model predicts the FIFO entries each packet should produce.
module tb_usb_fs_rx_packetizer;

  localparam int unsigned DEPTH = 4;
  localparam logic [1:0] J = 2'b10, K = 2'b01, SE0 = 2'b00, SE1 = 2'b11;

  logic       clk = 1'b0;
  logic       rst, bit_stb, usb_dp, usb_dm, rx_ready;
  logic [7:0] rx_data;
  logic       rx_last, rx_err, rx_valid, rx_active, rx_ovf;
  logic [2:0] fifo_level;

  int vectors = 0;
  int miscompares = 0;
  int ovf_cnt = 0;
  int ovf0;

  logic [9:0] exp_q[$];  // {err, last, data}
  logic [7:0] pkt[$];
  bit         payload[$];
  int         pop_raw;
  bit         pop_eop;

  usb_fs_rx_packetizer #(
    .FIFO_DEPTH    (DEPTH),
    .SYNC_MIN_ZEROS(5),
    .EOP_SE0_BITS  (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bit_stb   (bit_stb),
    .usb_dp    (usb_dp),
    .usb_dm    (usb_dm),
    .rx_data   (rx_data),
    .rx_last   (rx_last),
    .rx_err    (rx_err),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_active (rx_active),
    .rx_ovf    (rx_ovf),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rx_ovf === 1'b1) ovf_cnt++;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One line symbol with a strobe; optionally pop the FIFO head in the decode cycle.
  task automatic send_ls(input logic [1:0] ls, input bit pop);
    @(negedge clk);
    {usb_dp, usb_dm} = ls;
    bit_stb = 1'b1;
    @(negedge clk);
    bit_stb = 1'b0;
    {usb_dp, usb_dm} = 2'($urandom);  // not sampled without the strobe
    if (pop) begin
      check("pop_head", {22'b0, rx_err, rx_last, rx_data}, {22'b0, exp_q[0]});
      void'(exp_q.pop_front());
      rx_ready = 1'b1;
    end
    @(negedge clk);
    rx_ready = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  // SYNC then NRZI of payload with bit stuffing; stuff insertion number skip_stuff is omitted.
  task automatic send_body(input int skip_stuff);
    logic [1:0] sync_pat [8];
    logic [1:0] cur;
    int ones, nstuff;
    sync_pat = '{K, J, K, J, K, J, K, K};
    foreach (sync_pat[i]) send_ls(sync_pat[i], 1'b0);
    cur = K;
    ones = 1;
    nstuff = 0;
    foreach (payload[i]) begin
      if (payload[i]) ones++;
      else begin
        cur = ~cur;
        ones = 0;
      end
      send_ls(cur, i == pop_raw);
      if (ones == 6) begin
        if (nstuff != skip_stuff) begin
          cur = ~cur;
          ones = 0;
          send_ls(cur, 1'b0);
        end
        nstuff++;
      end
    end
  endtask

  task automatic send_eop();
    send_ls(SE0, pop_eop);
    send_ls(SE0, 1'b0);
    send_ls(J, 1'b0);
    send_ls(J, 1'b0);
  endtask

  // Raw bits: pkt bytes LSB first, then `extra` random trailing bits.
  task automatic prep(input int extra);
    payload.delete();
    foreach (pkt[i]) for (int k = 0; k < 8; k++) payload.push_back(pkt[i][k]);
    repeat (extra) payload.push_back(1'($urandom));
  endtask

  // Every byte of pkt becomes an entry; the final one is last and carries err.
  task automatic expect_pkt(input bit err);
    foreach (pkt[i]) begin
      bit is_last;
      is_last = (i == pkt.size() - 1);
      exp_q.push_back({err & is_last, is_last, pkt[i]});
    end
  endtask

  task automatic drain();
    int waited;
    while (exp_q.size() > 0) begin
      waited = 0;
      while (rx_valid !== 1'b1 && waited < 100) begin
        @(negedge clk);
        waited++;
      end
      if (rx_valid !== 1'b1) begin
        check("valid_timeout", {31'b0, rx_valid}, 32'd1);
        exp_q.delete();
      end else begin
        check("entry", {22'b0, rx_err, rx_last, rx_data}, {22'b0, exp_q[0]});
        void'(exp_q.pop_front());
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
      end
    end
    repeat (3) @(negedge clk);
    check("drained_level", fifo_level, 0);
    check("drained_valid", rx_valid, 0);
  endtask

  initial begin
    rst = 1'b1;
    bit_stb = 1'b0;
    {usb_dp, usb_dm} = J;
    rx_ready = 1'b0;
    pop_raw = -1;
    pop_eop = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_valid", rx_valid, 0);
    check("rst_level", fifo_level, 0);
    check("rst_active", rx_active, 0);
    check("rst_data", rx_data, 0);
    check("rst_last", rx_last, 0);
    check("rst_err", rx_err, 0);
    check("rst_ovf", rx_ovf, 0);
    repeat (3) send_ls(J, 1'b0);

    // Two-byte clean packet
    pkt = '{8'hA5, 8'h3C};
    prep(0);
    expect_pkt(1'b0);
    send_body(-1);
    check("active_in_pkt", rx_active, 1);
    send_eop();
    check("active_after_eop", rx_active, 0);
    drain();

    // 0xFF needs a stuffed zero
    pkt = '{8'hFF};
    prep(0);
    expect_pkt(1'b0);
    send_body(-1);
    send_eop();
    drain();

    // Second 0xFF with its stuffed zero omitted: stuff error
    pkt = '{8'hFF, 8'hFF};
    prep(0);
    exp_q.push_back({1'b1, 1'b1, 8'hFF});
    send_body(1);
    check("active_after_stuff_err", rx_active, 0);
    send_eop();
    drain();

    // Unaligned EOP
    pkt = '{8'h12};
    prep(5);
    expect_pkt(1'b1);
    send_body(-1);
    send_eop();
    drain();

    // Zero-byte packet
    pkt.delete();
    prep(0);
    send_body(-1);
    check("active_empty_pkt", rx_active, 1);
    send_eop();
    drain();

    // SE1 mid-packet
    pkt = '{8'h33, 8'h44};
    prep(3);
    expect_pkt(1'b1);
    send_body(-1);
    send_ls(SE1, 1'b0);
    check("active_after_se1", rx_active, 0);
    send_ls(K, 1'b0);
    send_ls(J, 1'b0);
    send_eop();
    drain();

    // Overflow: six bytes with no consumer
    pkt.delete();
    repeat (6) pkt.push_back(8'($urandom));
    prep(0);
    ovf0 = ovf_cnt;
    send_body(-1);
    @(negedge clk);
    check("ovf_level", fifo_level, DEPTH);
    check("ovf_pulses", ovf_cnt - ovf0, 1);
    check("ovf_active", rx_active, 0);
    send_eop();
    for (int i = 0; i < 4; i++) exp_q.push_back({2'b00, pkt[i]});
    drain();

    // Full FIFO with a pop in each push cycle
    pkt.delete();
    repeat (4) pkt.push_back(8'($urandom));
    prep(0);
    expect_pkt(1'b0);
    send_body(-1);
    send_eop();
    @(negedge clk);
    check("fill_level", fifo_level, DEPTH);
    pkt.delete();
    repeat (2) pkt.push_back(8'($urandom));
    prep(0);
    expect_pkt(1'b0);
    ovf0 = ovf_cnt;
    pop_raw = 15;
    pop_eop = 1'b1;
    send_body(-1);
    check("full_pop_level_mid", fifo_level, DEPTH);
    send_eop();
    pop_raw = -1;
    pop_eop = 1'b0;
    @(negedge clk);
    check("full_pop_level", fifo_level, DEPTH);
    check("full_pop_no_ovf", ovf_cnt - ovf0, 0);
    drain();

    // Reset mid-byte of a three-byte packet
    pkt = '{8'h11, 8'h22, 8'h33};
    prep(0);
    while (payload.size() > 20) void'(payload.pop_back());
    send_body(-1);
    check("pre_rst_level", fifo_level, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_valid", rx_valid, 0);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_active", rx_active, 0);
    check("mid_rst_data", rx_data, 0);
    repeat (3) send_ls(J, 1'b0);
    pkt = '{8'h5A};
    prep(0);
    expect_pkt(1'b0);
    send_body(-1);
    send_eop();
    drain();

    // Random packets, aligned or with trailing bits
    repeat (20) begin
      int n, extra;
      n = $urandom_range(0, 4);
      extra = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 7);
      pkt.delete();
      repeat (n) pkt.push_back(8'($urandom));
      prep(extra);
      expect_pkt(extra != 0);
      send_body(-1);
      send_eop();
      drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
